pe_mac_acc: RTL

Parametrised successor to the basic multiply-add processing element. It is a two-stage pipelined signed MAC with an internal multi-term accumulator for kernel reduction inside one PE, plus a systolic pass-through mode that computes px*w+Is on every valid input. A per-group partial-sum input, arithmetic right shift, output saturation and valid handshaking let convolution-array controllers chain PEs and drain results without external output registers.

---
 rtl/pe_pkg.sv | 12 +
 rtl/pe_sat_shift.sv | 31 +++
 rtl/pe_mac_acc.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the pipelined MAC processing element.
package pe_pkg;

   localparam logic PE_MODE_ACC  = 1'b0;
   localparam logic PE_MODE_PASS = 1'b1;

   // Term counter must hold 0..max_terms.
   function automatic int unsigned cnt_width(input int unsigned max_terms);
      return $clog2(max_terms + 1);
   endfunction

endpackage

// File: rtl/pe_sat_shift.sv
// Arithmetic right shift followed by signed saturation to the output width.
module pe_sat_shift #(
   parameter int unsigned ACC_WIDTH      = 40,
   parameter int unsigned DATA_OUT_WIDTH = 16,
   parameter int unsigned SHIFT          = 0
) (
   input  logic [ACC_WIDTH-1:0]      din,
   output logic [DATA_OUT_WIDTH-1:0] dout,
   output logic                      sat
);

   logic signed [ACC_WIDTH-1:0]        shifted;
   logic [ACC_WIDTH-DATA_OUT_WIDTH:0]  upper;
   logic                               fits;

   always_comb begin
      shifted = $signed(din) >>> SHIFT;
      // Value fits when every bit from the output sign bit upward agrees.
      upper   = shifted[ACC_WIDTH-1:DATA_OUT_WIDTH-1];
      fits    = (&upper) | ~(|upper);
      sat     = ~fits;
      if (fits) begin
         dout = shifted[DATA_OUT_WIDTH-1:0];
      end else if (shifted[ACC_WIDTH-1]) begin
         dout = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
      end else begin
         dout = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/pe_mac_acc.sv
// Two-stage signed MAC with a multi-term group accumulator and a pass-through mode.
module pe_mac_acc
   import pe_pkg::*;
#(
   parameter int unsigned PX_WIDTH       = 16,
   parameter int unsigned W_WIDTH        = 16,
   parameter int unsigned DATA_OUT_WIDTH = 16,
   parameter int unsigned ACC_WIDTH      = 40,
   parameter int unsigned MAX_TERMS      = 9,
   parameter int unsigned SHIFT          = 0
) (
   input  logic                      PEA_Clk,
   input  logic                      PEA_Reset,
   input  logic                      PEA_Clear,
   input  logic                      PEA_Mode,
   input  logic                      PEA_In_Valid,
   input  logic                      PEA_Last,
   input  logic [DATA_OUT_WIDTH-1:0] PEA_Is,
   input  logic [PX_WIDTH-1:0]       PEA_If_Px,
   input  logic [W_WIDTH-1:0]        PEA_w,
   output logic [DATA_OUT_WIDTH-1:0] PEA_Out,
   output logic                      PEA_Out_Valid,
   output logic                      PEA_Sat,
   output logic                      PEA_Busy
);

   localparam int unsigned PROD_W = PX_WIDTH + W_WIDTH;
   localparam int unsigned CNT_W  = cnt_width(MAX_TERMS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);

   logic [PROD_W-1:0]         px_ext, w_ext, prod;
   logic [PROD_W-1:0]         s1_prod_q;
   logic [DATA_OUT_WIDTH-1:0] s1_is_q;
   logic                      s1_last_q, s1_mode_q, s1_valid_q;
   logic [ACC_WIDTH-1:0]      acc_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      mode_q;
   logic [DATA_OUT_WIDTH-1:0] out_q;
   logic                      out_valid_q, sat_q;

   logic                      busy, eff_mode, first, close, acc_term;
   logic [ACC_WIDTH-1:0]      prod_sx, is_sx, sum;
   logic [DATA_OUT_WIDTH-1:0] res;
   logic                      res_sat;

   // Sign-extend both operands so the truncated product is the exact signed product.
   assign px_ext = {{W_WIDTH{PEA_If_Px[PX_WIDTH-1]}}, PEA_If_Px};
   assign w_ext  = {{PX_WIDTH{PEA_w[W_WIDTH-1]}}, PEA_w};
   assign prod   = px_ext * w_ext;

   // Mode is frozen while a group is open.
   assign busy     = (cnt_q != '0);
   assign eff_mode = busy ? mode_q : PEA_Mode;

   always_comb begin
      prod_sx  = {{(ACC_WIDTH-PROD_W){s1_prod_q[PROD_W-1]}}, s1_prod_q};
      is_sx    = {{(ACC_WIDTH-DATA_OUT_WIDTH){s1_is_q[DATA_OUT_WIDTH-1]}}, s1_is_q};
      first    = (cnt_q == '0);
      acc_term = s1_valid_q && (s1_mode_q == PE_MODE_ACC);
      if ((s1_mode_q == PE_MODE_PASS) || first) begin
         sum = is_sx + prod_sx;
      end else begin
         sum = acc_q + prod_sx;
      end
      close = s1_valid_q &&
              ((s1_mode_q == PE_MODE_PASS) || s1_last_q || (cnt_q == CNT_LAST));
   end

   pe_sat_shift #(
      .ACC_WIDTH      (ACC_WIDTH),
      .DATA_OUT_WIDTH (DATA_OUT_WIDTH),
      .SHIFT          (SHIFT)
   ) u_sat_shift (
      .din  (sum),
      .dout (res),
      .sat  (res_sat)
   );

   always_ff @(posedge PEA_Clk or negedge PEA_Reset) begin
      if (!PEA_Reset) begin
         s1_prod_q   <= '0;
         s1_is_q     <= '0;
         s1_last_q   <= 1'b0;
         s1_mode_q   <= PE_MODE_ACC;
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= PE_MODE_ACC;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else if (PEA_Clear) begin
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         s1_valid_q <= PEA_In_Valid;
         if (PEA_In_Valid) begin
            s1_prod_q <= prod;
            s1_is_q   <= PEA_Is;
            s1_last_q <= PEA_Last;
            s1_mode_q <= eff_mode;
            mode_q    <= eff_mode;
         end
         out_valid_q <= close;
         if (close) begin
            out_q <= res;
            sat_q <= res_sat;
         end
         if (acc_term) begin
            acc_q <= sum;
            cnt_q <= close ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

   assign PEA_Out       = out_q;
   assign PEA_Out_Valid = out_valid_q;
   assign PEA_Sat       = sat_q;
   assign PEA_Busy      = busy;

endmodule
